// File: rtl/reg_file_wb_pkg.sv
// Shared definitions for the CPU register file: default widths, architectural
// register names and the read-source encoding used by the read ports.
package reg_file_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Architectural register indices referenced by the CPU datapath.
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_AT   = 5'd1;
  localparam logic [4:0] REG_V0   = 5'd2;
  localparam logic [4:0] REG_A0   = 5'd4;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_FP   = 5'd30;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Where a read port takes its data from in the current cycle.
  typedef enum logic [1:0] {
    RD_STORED = 2'd0,
    RD_BYPASS = 2'd1,
    RD_ZERO   = 2'd2
  } rd_src_e;

endpackage

// File: rtl/dec5to32.sv
// Combinational index-to-one-hot decoder with enable; all outputs low when
// the enable is low.
module dec5to32
  import reg_file_wb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < 2**ADDR_W; gi++) begin : g_bit
      assign onehot[gi] = en & (addr == ADDR_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/reg_file_wb.sv
// 32-entry CPU register file: one synchronous write port driven by the
// write-back destination, two combinational read ports, register 0 reads zero.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [ADDR_W-1:0]    raddr1,
  input  logic [ADDR_W-1:0]    raddr2,
  output logic [DATA_W-1:0]    rdata1,
  output logic [DATA_W-1:0]    rdata2,
  output logic [2**ADDR_W-1:0] wr_onehot
);

  localparam int                NREG     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic                         we_eff;
  logic [NREG-1:0]              wr_sel;
  logic [DATA_W-1:0]            regs_reg [NREG];
  logic [NREG-1:0]              wr_onehot_reg;
  logic [1:0][ADDR_W-1:0]       raddr_vec;
  logic [1:0][DATA_W-1:0]       rdata_vec;

  // Reset also masks the effective write so the bypass path cannot leak
  // write data onto the read ports while the file is being cleared.
  assign we_eff = we & ~reset & (waddr != ZERO_IDX);

  dec5to32 #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .en     (we_eff),
    .addr   (waddr),
    .onehot (wr_sel)
  );

  // Entry 0 is never selected by the decoder, so it holds its reset value
  // and is optimised away; the read ports force zero for it regardless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
      wr_onehot_reg <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_sel[i]) begin
          regs_reg[i] <= wdata;
        end
      end
      wr_onehot_reg <= wr_sel;
    end
  end

  assign wr_onehot = wr_onehot_reg;

  assign raddr_vec[0] = raddr1;
  assign raddr_vec[1] = raddr2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      rd_src_e           src;
      logic [DATA_W-1:0] val;

      always_comb begin
        src = RD_STORED;
        if (raddr_vec[gi] == ZERO_IDX) begin
          src = RD_ZERO;
        end else if (BYPASS && we_eff && (raddr_vec[gi] == waddr)) begin
          src = RD_BYPASS;
        end
      end

      always_comb begin
        val = regs_reg[raddr_vec[gi]];
        case (src)
          RD_ZERO:   val = '0;
          RD_BYPASS: val = wdata;
          default:   val = regs_reg[raddr_vec[gi]];
        endcase
      end

      assign rdata_vec[gi] = val;
    end
  endgenerate

  assign rdata1 = rdata_vec[0];
  assign rdata2 = rdata_vec[1];

endmodule
